bp_stream_host_ctrl: RTL and testbench

// Sequencing/arbitration controller for the host stream port of the FPGA host bridge. Steers incoming

---
 rtl/bp_stream_host_ctrl.sv | 154 +++++++++++++++
 tb/tb_bp_stream_host_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_stream_host_ctrl.sv
// Host stream port controller: address steering, LOAD->RUN bring-up FSM with watchdog,
// and a registered round-robin merge of MMIO responses and status onto the outbound stream.
module bp_stream_host_ctrl #(
    parameter int unsigned stream_addr_width_p = 32,
    parameter int unsigned stream_data_width_p = 32,
    parameter int unsigned nbf_addr_p          = 'h10,
    parameter int unsigned mmio_addr_p         = 'h20,
    parameter int unsigned ctrl_addr_p         = 'h30,
    parameter int unsigned timeout_width_p     = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           stream_v_i,
    input  logic [stream_addr_width_p-1:0] stream_addr_i,
    input  logic [stream_data_width_p-1:0] stream_data_i,
    output logic                           stream_yumi_o,
    output logic                           nbf_v_o,
    output logic [stream_data_width_p-1:0] nbf_data_o,
    input  logic                           nbf_ready_i,
    output logic                           mmio_v_o,
    output logic [stream_data_width_p-1:0] mmio_data_o,
    input  logic                           mmio_ready_i,
    input  logic                           prog_done_i,
    input  logic                           resp_v_i,
    input  logic [stream_data_width_p-1:0] resp_data_i,
    output logic                           resp_yumi_o,
    output logic                           stream_v_o,
    output logic [stream_data_width_p-1:0] stream_data_o,
    input  logic                           stream_ready_i,
    output logic [1:0]                     state_o,
    output logic                           error_o
);

    localparam int unsigned SA = stream_addr_width_p;
    localparam int unsigned SD = stream_data_width_p;
    localparam int unsigned TW = timeout_width_p;
    localparam logic [TW-1:0] WD_MAX = '1;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ERROR = 2'd2
    } state_e;

    state_e         state, state_next;
    logic [TW-1:0]  wdog, wdog_next;
    logic [3:0]     err, err_next;
    logic           status_pend;
    logic           last_mmio;
    logic           out_v;
    logic [SD-1:0]  out_data;

    logic is_nbf, is_mmio, is_ctrl;
    logic nbf_accept, restart, status_req;
    logic [3:0] drop_err;
    logic load_en, grant_resp, grant_status;
    logic [SD-1:0] status_word;

    // Address decode and zero-cycle steering of the inbound word
    always_comb begin
        is_nbf   = (stream_addr_i == SA'(nbf_addr_p));
        is_mmio  = (stream_addr_i == SA'(mmio_addr_p));
        is_ctrl  = (stream_addr_i == SA'(ctrl_addr_p));
        nbf_v_o  = stream_v_i & is_nbf & (state == ST_LOAD);
        mmio_v_o = stream_v_i & is_mmio & (state == ST_RUN);
        if (nbf_v_o) begin
            stream_yumi_o = nbf_ready_i;
        end else if (mmio_v_o) begin
            stream_yumi_o = mmio_ready_i;
        end else begin
            stream_yumi_o = stream_v_i;
        end
        nbf_accept = nbf_v_o & nbf_ready_i;
        restart    = stream_v_i & is_ctrl & stream_data_i[0];
        status_req = stream_v_i & is_ctrl & stream_data_i[1];
        drop_err   = {1'b0,
                      stream_v_i & ~is_nbf & ~is_mmio & ~is_ctrl,
                      stream_v_i & is_mmio & (state != ST_RUN),
                      stream_v_i & is_nbf & (state != ST_LOAD)};
    end

    assign nbf_data_o  = stream_data_i;
    assign mmio_data_o = stream_data_i;

    // Bring-up FSM and watchdog; a restart command overrides everything else
    always_comb begin
        state_next = state;
        wdog_next  = '0;
        err_next   = err | drop_err;
        if (state == ST_LOAD) begin
            if (nbf_accept) begin
                wdog_next = '0;
            end else if (wdog == WD_MAX) begin
                wdog_next = wdog;
            end else begin
                wdog_next = wdog + TW'(1);
            end
            if (prog_done_i) begin
                state_next = ST_RUN;
            end else if (wdog_next == WD_MAX) begin
                state_next  = ST_ERROR;
                err_next[3] = 1'b1;
            end
        end
        if (restart) begin
            state_next = ST_LOAD;
            wdog_next  = '0;
            err_next   = '0;
        end
    end

    // Round-robin between MMIO responses and the pending status word
    always_comb begin
        load_en      = ~out_v | stream_ready_i;
        grant_resp   = load_en & resp_v_i & (~status_pend | ~last_mmio);
        grant_status = load_en & status_pend & (~resp_v_i | last_mmio);
        status_word  = SD'({err, 2'b00, state});
    end

    assign resp_yumi_o = grant_resp;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= ST_LOAD;
            wdog        <= '0;
            err         <= '0;
            status_pend <= 1'b0;
            last_mmio   <= 1'b1;
            out_v       <= 1'b0;
            out_data    <= '0;
        end else begin
            state       <= state_next;
            wdog        <= wdog_next;
            err         <= err_next;
            status_pend <= (status_pend & ~grant_status) | status_req;
            if (load_en) begin
                out_v <= grant_resp | grant_status;
                if (grant_resp) begin
                    out_data  <= resp_data_i;
                    last_mmio <= 1'b1;
                end else if (grant_status) begin
                    out_data  <= status_word;
                    last_mmio <= 1'b0;
                end
            end
        end
    end

    assign stream_v_o    = out_v;
    assign stream_data_o = out_data;
    assign state_o       = state;
    assign error_o       = |err;

endmodule

// File: tb/tb_bp_stream_host_ctrl.sv
// Bench for bp_stream_host_ctrl: directed bring-up/error/arbiter/stall/reset scenarios plus
// randomized traffic, all checked against a transaction-level model of the controller.
module tb_bp_stream_host_ctrl;

    logic        clk;
    logic        rst_n;
    logic        s_v;
    logic [31:0] s_addr;
    logic [31:0] s_data;
    logic        s_yumi;
    logic        nbf_v;
    logic [31:0] nbf_data;
    logic        nbf_ready;
    logic        mmio_v;
    logic [31:0] mmio_data;
    logic        mmio_ready;
    logic        prog_done;
    logic        r_v;
    logic [31:0] r_data;
    logic        r_yumi;
    logic        o_v;
    logic [31:0] o_data;
    logic        o_ready;
    logic [1:0]  st;
    logic        err_o;

    bp_stream_host_ctrl #(.timeout_width_p(4)) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .stream_v_i(s_v), .stream_addr_i(s_addr), .stream_data_i(s_data), .stream_yumi_o(s_yumi),
        .nbf_v_o(nbf_v), .nbf_data_o(nbf_data), .nbf_ready_i(nbf_ready),
        .mmio_v_o(mmio_v), .mmio_data_o(mmio_data), .mmio_ready_i(mmio_ready),
        .prog_done_i(prog_done),
        .resp_v_i(r_v), .resp_data_i(r_data), .resp_yumi_o(r_yumi),
        .stream_v_o(o_v), .stream_data_o(o_data), .stream_ready_i(o_ready),
        .state_o(st), .error_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: 0 LOAD, 1 RUN, 2 ERROR; idle LOAD cycles counted up to a 15-cycle limit
    int          m_state;
    int          m_idle;
    bit [3:0]    m_err;
    bit          m_pend;
    bit          m_ov;
    bit [31:0]   m_od;
    bit          m_last_resp;
    int          tests;
    int          fails;
    logic [31:0] held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_idle = 0; m_err = 4'h0; m_pend = 1'b0;
        m_ov = 1'b0; m_od = 32'h0; m_last_resp = 1'b1;
    endtask

    task automatic set_idle();
        s_v = 1'b0; s_addr = 32'h0; s_data = 32'h0; nbf_ready = 1'b0; mmio_ready = 1'b0;
        prog_done = 1'b0; r_v = 1'b0; r_data = 32'h0; o_ready = 1'b1;
    endtask

    // One clock: check combinational and registered outputs against the model, then advance it
    task automatic cycle();
        bit nbf_hit, mmio_hit, ctrl_hit, can_load, exp_yumi;
        int pick;
        bit [31:0] status;
        #2;
        nbf_hit  = s_v && s_addr == 32'h10 && m_state == 0;
        mmio_hit = s_v && s_addr == 32'h20 && m_state == 1;
        ctrl_hit = s_v && s_addr == 32'h30;
        exp_yumi = nbf_hit ? nbf_ready : (mmio_hit ? mmio_ready : s_v);
        can_load = !m_ov || o_ready;
        pick = 0;
        if (can_load) begin
            if (r_v && m_pend) pick = m_last_resp ? 2 : 1;
            else if (r_v)      pick = 1;
            else if (m_pend)   pick = 2;
        end
        chk("nbf_v", 32'(nbf_v), 32'(nbf_hit));
        chk("mmio_v", 32'(mmio_v), 32'(mmio_hit));
        chk("yumi", 32'(s_yumi), 32'(exp_yumi));
        chk("resp_yumi", 32'(r_yumi), 32'(pick == 1));
        chk("state", 32'(st), 32'(m_state));
        chk("error", 32'(err_o), 32'(m_err != 0));
        chk("out_v", 32'(o_v), 32'(m_ov));
        if (m_ov) chk("out_data", o_data, m_od);
        if (nbf_hit) chk("nbf_data", nbf_data, s_data);
        if (mmio_hit) chk("mmio_data", mmio_data, s_data);
        @(posedge clk);
        status = (32'(m_err) << 4) | 32'(m_state);
        if (can_load) begin
            m_ov = (pick != 0);
            if (pick == 1) begin m_od = r_data; m_last_resp = 1'b1; end
            if (pick == 2) begin m_od = status; m_last_resp = 1'b0; end
        end
        if (s_v && s_addr == 32'h10 && m_state != 0) m_err[0] = 1'b1;
        if (s_v && s_addr == 32'h20 && m_state != 1) m_err[1] = 1'b1;
        if (s_v && s_addr != 32'h10 && s_addr != 32'h20 && s_addr != 32'h30) m_err[2] = 1'b1;
        if (m_state == 0) begin
            if (nbf_hit && nbf_ready) m_idle = 0;
            else if (m_idle < 15)     m_idle = m_idle + 1;
            if (prog_done) m_state = 1;
            else if (m_idle == 15) begin m_state = 2; m_err[3] = 1'b1; end
        end else begin
            m_idle = 0;
        end
        if (ctrl_hit && s_data[0]) begin m_state = 0; m_idle = 0; m_err = 4'h0; end
        m_pend = (m_pend && pick != 2) || (ctrl_hit && s_data[1]);
        #1;
    endtask

    task automatic word(input logic [31:0] addr, input logic [31:0] data);
        s_v = 1'b1; s_addr = addr; s_data = data;
        cycle();
        s_v = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #3;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        tests = 0; fails = 0;
        set_idle();
        rst_n = 1'b0;
        model_reset();
        #12;
        chk("rst_state", 32'(st), 32'd0);
        chk("rst_out_v", 32'(o_v), 32'd0);
        chk("rst_error", 32'(err_o), 32'd0);
        chk("rst_yumi", 32'(s_yumi), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Bring-up: NBF words then prog_done
        nbf_ready = 1'b1;
        for (int i = 0; i < 4; i++) word(32'h10, $urandom);
        prog_done = 1'b1;
        cycle();
        prog_done = 1'b0;
        chk("run_entry", 32'(st), 32'd1);
        chk("run_no_err", 32'(err_o), 32'd0);

        // Drops in LOAD set err bits 1 and 2; read them back through a status word
        word(32'h30, 32'h1);
        word(32'h20, $urandom);
        word(32'h44, $urandom);
        chk("load_err", 32'(err_o), 32'd1);
        word(32'h30, 32'h2);
        cycle();
        chk("load_status_v", 32'(o_v), 32'd1);
        chk("load_status", o_data, 32'h60);

        // Watchdog: restart then 15 idle cycles
        word(32'h30, 32'h1);
        for (int i = 0; i < 14; i++) cycle();
        chk("wd_before", 32'(st), 32'd0);
        cycle();
        chk("wd_timeout", 32'(st), 32'd2);
        chk("wd_error", 32'(err_o), 32'd1);
        word(32'h30, 32'h1);
        chk("restart_state", 32'(st), 32'd0);
        chk("restart_error", 32'(err_o), 32'd0);

        // RUN: responses held valid with repeated status requests alternate on the output
        prog_done = 1'b1;
        cycle();
        prog_done = 1'b0;
        r_v = 1'b1;
        for (int i = 0; i < 8; i++) begin
            r_data = $urandom;
            word(32'h30, 32'h2);
        end
        for (int i = 0; i < 3; i++) begin r_data = $urandom; cycle(); end

        // Stall with a valid outbound word, then release
        held = o_data;
        o_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            r_data = $urandom;
            cycle();
            chk("stall_data", o_data, held);
        end
        o_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin r_data = $urandom; cycle(); end
        set_idle();
        cycle();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            int sel;
            sel = int'($urandom_range(0, 3));
            s_v    = ($urandom_range(0, 1) == 1);
            s_addr = (sel == 0) ? 32'h10 : (sel == 1) ? 32'h20 : (sel == 2) ? 32'h30 : 32'($urandom_range(0, 63));
            s_data = $urandom;
            if (s_addr == 32'h30 && $urandom_range(0, 15) != 0) s_data[0] = 1'b0;
            nbf_ready  = ($urandom_range(0, 3) != 0);
            mmio_ready = ($urandom_range(0, 1) == 1);
            prog_done  = ($urandom_range(0, 19) == 0);
            r_v        = ($urandom_range(0, 2) != 0);
            r_data     = $urandom;
            o_ready    = ($urandom_range(0, 3) != 0);
            cycle();
        end
        set_idle();

        // Async reset mid-LOAD with an outbound word held
        word(32'h30, 32'h1);
        word(32'h55, 32'h0);
        r_v = 1'b1; r_data = 32'hABCD0123; o_ready = 1'b0;
        cycle();
        r_v = 1'b0;
        cycle();
        chk("pre_rst_out_v", 32'(o_v), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_state", 32'(st), 32'd0);
        chk("async_out_v", 32'(o_v), 32'd0);
        chk("async_error", 32'(err_o), 32'd0);
        chk("async_resp_yumi", 32'(r_yumi), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        o_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
